fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each requester word and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter BURST_MAX, default 8, maximum words accepted per grant (1..255).
REQ-004 SHALL have port clk_write  input  1  single clock, rising edge; the FIFO write-domain clock.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester "word valid" request.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester words; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port ack  output  NUM_REQ  one-hot; word from requester i accepted this cycle.
REQ-009 SHALL have port grant  output  NUM_REQ  registered one-hot current owner; all-zero when idle.
REQ-010 SHALL have port fifo_full  input  1  FIFO full flag, write-domain synchronous.
REQ-011 SHALL have port fifo_write  output  1  FIFO write strobe.
REQ-012 SHALL have port fifo_data_write  output  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port busy  output  1  high while in BURST state.

Function
REQ-014 FSM SHALL have two states, IDLE and BURST.
REQ-015 IDLE: if any req bit is set and fifo_full is low, SHALL register grant to the round-robin winner, clear the beat counter, and enter BURST next cycle; otherwise remain in IDLE.
REQ-016 Round-robin SHALL search from index (last_owner+1) mod NUM_REQ upward with wrap; last_owner resets to NUM_REQ-1, so requester 0 wins first.
REQ-017 A word SHALL be accepted in a cycle iff state==BURST, req[g]==1, and fifo_full==0, where g is the granted index.
REQ-018 On accept, fifo_write, ack[g] and fifo_data_write SHALL be driven combinationally in the same cycle; fifo_data_write SHALL equal the slice of requester g.
REQ-019 fifo_write and ack SHALL be 0 in every cycle with no accept; fifo_data_write SHALL be 0 when grant is all-zero.
REQ-020 Beat counter SHALL increment on each accept; its width is clog2(BURST_MAX+1).
REQ-021 In BURST, SHALL return to IDLE (clear grant, set last_owner=g) in the cycle after the accept that makes beat count equal BURST_MAX.
REQ-022 In BURST, SHALL return to IDLE in the cycle after req[g] is sampled low, including when fifo_full is also high.
REQ-023 When req[g] is high and fifo_full is high, SHALL hold grant and count and accept nothing: a stall with no timeout.
REQ-024 Changes to req of non-granted requesters during BURST SHALL have no effect.
REQ-025 Minimum gap between bursts SHALL be one IDLE cycle; back-to-back requesters alternate in round-robin order.

Reset
REQ-026 On rst_n low, state SHALL be IDLE, grant=0, busy=0, beat counter=0, last_owner=NUM_REQ-1; ack, fifo_write and fifo_data_write SHALL be 0 while reset is asserted.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately; a word presented in that cycle is not accepted.
REQ-028 The first grant after reset release SHALL occur no earlier than the second rising edge.

Structure
REQ-029 Shared package SHALL hold the state enumeration (IDLE, BURST) and a round-robin-next-index function.
REQ-030 The round-robin picker SHALL be a sub-module, rr_pick, with combinational inputs req and last_owner and a one-hot winner output; all registers remain in fifo_write_arbiter.

Verification
REQ-031 Single requester: req[2]=1 held for 20 cycles with FIFO not full -> grant=0100 after 1 cycle, 8 acks, 1 idle cycle, regrant; 16 writes total with data matching.
REQ-032 All four requesters hold req continuously -> grants in order 0,1,2,3,0, each burst exactly 8 fifo_write pulses, no two acks in one cycle.
REQ-033 fifo_full=1 for 5 cycles mid-burst at beat 3 -> no writes during those 5 cycles, grant held, burst resumes and ends at 8 beats.
REQ-034 req[1] drops after 3 beats -> busy falls the next cycle, last_owner=1, next winner is 2 if requesting.
REQ-035 rst_n pulsed low at beat 5 -> same-cycle fifo_write=0, grant=0; after release, requester 0 wins first.
REQ-036 fifo_full=1 while in IDLE with req=1111 -> no grant until fifo_full falls, then grant is issued one cycle later.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_pkg
// Shared definitions for the FIFO write arbiter:
//   - arb_state_e   : arbiter FSM state encoding (IDLE / BURST)
//   - rr_next_index : first index the round-robin search looks at, given the
//                     previous owner (wraps to 0 after the last requester)
// -----------------------------------------------------------------------------
package fifo_write_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Start point of the round-robin search: (last + 1) mod num.
    function automatic int rr_next_index(input int last, input int num);
        return (last + 1 >= num) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req_i starting at
// (last_owner_i + 1) mod NUM_REQ, wrapping upward, and flags the first
// requester found.
// Ports:
//   req_i        in  NUM_REQ  request vector
//   last_owner_i in  IDX_W    index of the previous burst owner
//   winner_o     out NUM_REQ  one-hot winner, all-zero when nobody requests
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [NUM_REQ-1:0] winner_o
);

    always_comb begin
        int               start;
        int               idx;
        logic [IDX_W-1:0] idx_w;
        logic             found;

        winner_o = '0;
        found    = 1'b0;
        start    = rr_next_index(int'(last_owner_i), NUM_REQ);
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = IDX_W'(idx);
            if (!found && req_i[idx_w]) begin
                winner_o[idx_w] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Multiplexes NUM_REQ word streams into one FIFO write port. An owner is
// picked round-robin in IDLE and keeps the port for a burst of up to
// BURST_MAX words; the burst ends early when the owner drops its request.
// A full FIFO stalls the burst indefinitely without losing ownership.
// Ports:
//   clk_write       in  1                   write-domain clock (rising edge)
//   rst_n           in  1                   async active-low reset
//   req             in  NUM_REQ             per-requester word valid
//   req_data        in  NUM_REQ*DATA_WIDTH  requester words, slice i = req i
//   ack             out NUM_REQ             one-hot: word of owner taken now
//   grant           out NUM_REQ             registered one-hot owner, 0 idle
//   fifo_full       in  1                   FIFO full flag
//   fifo_write      out 1                   FIFO write strobe
//   fifo_data_write out DATA_WIDTH          FIFO write data (owner's word)
//   busy            out 1                   high while a burst is active
// -----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                          clk_write,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_data_write,
    output logic                          busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    // Goes high on the first edge after reset release; granting is held off
    // until then so the first grant lands on the second edge at the earliest.
    logic               armed_q;

    logic [NUM_REQ-1:0] winner;
    logic [IDX_W-1:0]   owner_idx;
    logic               owner_req;
    logic               accept;
    logic [BEAT_W-1:0]  beat_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .winner_o     (winner)
    );

    // Encode the one-hot owner to an index for last_owner bookkeeping.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = IDX_W'(i);
            end
        end
    end

    // Only the owner's request bit matters; other requesters are ignored.
    assign owner_req = |(req & grant_q);
    assign accept    = rst_n && (state_q == ST_BURST) && owner_req && !fifo_full;
    assign beat_inc  = beat_q + BEAT_W'(1);

    assign fifo_write = accept;
    assign ack        = accept ? grant_q : '0;
    assign grant      = grant_q;
    assign busy       = (state_q == ST_BURST);

    // AND-OR mux on the one-hot grant: yields zero automatically when idle.
    logic [DATA_WIDTH-1:0] masked_word [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_word[gi] = grant_q[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                                 : '0;
        end
    endgenerate

    always_comb begin
        fifo_data_write = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_data_write = fifo_data_write | masked_word[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_d       = beat_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && (|req) && !fifo_full) begin
                    grant_d = winner;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!owner_req) begin
                    // Owner withdrew (even if the FIFO is also full): release.
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_idx;
                end else if (accept) begin
                    beat_d = beat_inc;
                    if (beat_inc == BEAT_W'(BURST_MAX)) begin
                        state_d      = ST_IDLE;
                        grant_d      = '0;
                        last_owner_d = owner_idx;
                    end
                end
                // else: FIFO full with owner still requesting -> hold.
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            beat_q       <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            beat_q       <= beat_d;
            last_owner_q <= last_owner_d;
            armed_q      <= 1'b1;
        end
    end

endmodule
